// File: rtl/zombie_pkg.sv
// Shared types and constants for the zombie wave engine.
// The lane band constants are also used by the pixel colour logic.
package zombie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_NEXT,
    ST_LOSE,
    ST_WIN
  } state_e;

  localparam logic [7:0] OH_I     = 8'h01;
  localparam logic [7:0] OH_L1    = 8'h02;
  localparam logic [7:0] OH_NL2   = 8'h04;
  localparam logic [7:0] OH_L2    = 8'h08;
  localparam logic [7:0] OH_NL3   = 8'h10;
  localparam logic [7:0] OH_L3    = 8'h20;
  localparam logic [7:0] OH_DONEL = 8'h40;
  localparam logic [7:0] OH_DONEW = 8'h80;

  localparam int DEF_X_START     = 799;
  localparam int DEF_END_OF_LAWN = 0;

  localparam int LANE_Y_TOP  = 80;
  localparam int LANE_HEIGHT = 80;

  function automatic int lane_y_top(input int lane);
    return LANE_Y_TOP + lane * LANE_HEIGHT;
  endfunction

  // Levels beyond 3 share the level-3 codes; the display only has three.
  function automatic logic [7:0] state_onehot(input state_e st, input logic [2:0] lvl);
    logic [7:0] oh;
    oh = OH_I;
    case (st)
      ST_IDLE: oh = OH_I;
      ST_PLAY: oh = (lvl == 3'd1) ? OH_L1 : (lvl == 3'd2) ? OH_L2 : OH_L3;
      ST_NEXT: oh = (lvl == 3'd1) ? OH_NL2 : OH_NL3;
      ST_LOSE: oh = OH_DONEL;
      default: oh = OH_DONEW;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/zombie_lane.sv
// One lawn row: zombie X position, pea hit count and alive flag.
// A killing hit takes priority over movement on the same edge.
module zombie_lane
  import zombie_pkg::*;
#(
  parameter int X_W          = 10,
  parameter int X_START      = DEF_X_START,
  parameter int END_OF_LAWN  = DEF_END_OF_LAWN,
  parameter int HITS_TO_KILL = 5,
  parameter int HIT_W        = 4,
  parameter int STEP_W       = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reload,
  input  logic              launch,
  input  logic              tick,
  input  logic [STEP_W-1:0] step,
  input  logic              hit,
  output logic [X_W-1:0]    x,
  output logic              alive,
  output logic              killed_pulse,
  output logic              at_end
);

  localparam logic [X_W:0] END_WIDE = (X_W+1)'(END_OF_LAWN);

  logic [X_W-1:0]   r_x;
  logic [HIT_W-1:0] r_hits;
  logic             r_alive;
  logic [X_W-1:0]   w_x_moved;
  logic             w_hit_ok;
  logic             w_kill;
  logic             w_move;

  // Hits only count while alive, so the counter stops at HITS_TO_KILL.
  assign w_hit_ok = hit && r_alive;
  assign w_kill   = w_hit_ok && (r_hits == HIT_W'(HITS_TO_KILL - 1));
  assign w_move   = tick && (r_alive || launch) && !w_kill;

  always_comb begin
    w_x_moved = r_x - X_W'(step);
    if ({1'b0, r_x} <= END_WIDE + (X_W+1)'(step))
      w_x_moved = X_W'(END_OF_LAWN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= X_W'(X_START);
      r_hits  <= '0;
      r_alive <= 1'b0;
    end else if (reload) begin
      r_x     <= X_W'(X_START);
      r_hits  <= '0;
      r_alive <= 1'b0;
    end else begin
      if (w_hit_ok)
        r_hits <= r_hits + 1'b1;
      if (w_kill) begin
        r_alive <= 1'b0;
      end else if (w_move) begin
        r_x     <= w_x_moved;
        r_alive <= 1'b1;
      end
    end
  end

  assign x            = r_x;
  assign alive        = r_alive;
  assign killed_pulse = w_kill;
  assign at_end       = r_alive && (r_x == X_W'(END_OF_LAWN));

endmodule

// File: rtl/zombie_wave_ctrl.sv
// Multi-lane zombie wave engine: level FSM, movement tick divider,
// staggered lane launches and the saturating kill counter.
module zombie_wave_ctrl
  import zombie_pkg::*;
#(
  parameter int NUM_LANES    = 5,
  parameter int X_W          = 10,
  parameter int X_START      = DEF_X_START,
  parameter int END_OF_LAWN  = DEF_END_OF_LAWN,
  parameter int TICK_DIV     = 500000,
  parameter int HITS_TO_KILL = 5,
  parameter int HIT_W        = 4,
  parameter int KILL_W       = 16,
  parameter int NUM_LEVELS   = 3,
  parameter int LAUNCH_GAP   = 40
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NUM_LANES-1:0]     hit_valid,
  output logic [NUM_LANES*X_W-1:0] zombie_x,
  output logic [NUM_LANES-1:0]     zombie_alive,
  output logic [KILL_W-1:0]        zombies_killed,
  output logic [2:0]               level,
  output logic [7:0]               state,
  output logic                     tick
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  // The launch counter parks one past the last launch so no lane relaunches.
  localparam int LC_MAX = (NUM_LANES - 1) * LAUNCH_GAP + 1;
  localparam int LC_W   = $clog2(LC_MAX + 1);
  localparam int PC_W   = $clog2(NUM_LANES + 1);

  state_e              r_state, w_state_next;
  logic [2:0]          r_level, w_level_next;
  logic [7:0]          r_state_oh;
  logic [DIV_W-1:0]    r_div;
  logic [LC_W-1:0]     r_launch_cnt;
  logic [KILL_W-1:0]   r_killed;
  logic [NUM_LANES-1:0] r_dead;

  logic                 w_playing;
  logic                 w_tick;
  logic                 w_reload;
  logic                 w_clear_kills;
  logic [NUM_LANES-1:0] w_launch;
  logic [NUM_LANES-1:0] w_kill_pulse;
  logic [NUM_LANES-1:0] w_at_end;
  logic [PC_W-1:0]      w_kill_cnt;
  logic [KILL_W:0]      w_kill_sum;

  assign w_playing = (r_state == ST_PLAY);
  assign w_tick    = w_playing && (r_div == DIV_W'(TICK_DIV - 1));

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign w_launch[gi] = w_tick && (r_launch_cnt == LC_W'(gi * LAUNCH_GAP));

    zombie_lane #(
      .X_W          (X_W),
      .X_START      (X_START),
      .END_OF_LAWN  (END_OF_LAWN),
      .HITS_TO_KILL (HITS_TO_KILL),
      .HIT_W        (HIT_W),
      .STEP_W       (3)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .reload       (w_reload),
      .launch       (w_launch[gi]),
      .tick         (w_tick),
      .step         (r_level),
      .hit          (hit_valid[gi] && w_playing),
      .x            (zombie_x[gi*X_W +: X_W]),
      .alive        (zombie_alive[gi]),
      .killed_pulse (w_kill_pulse[gi]),
      .at_end       (w_at_end[gi])
    );
  end

  always_comb begin
    w_kill_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_kill_cnt = w_kill_cnt + PC_W'(w_kill_pulse[i]);
  end

  assign w_kill_sum = {1'b0, r_killed} + (KILL_W+1)'(w_kill_cnt);

  // A zombie at the end of the lawn beats a simultaneous level clear.
  always_comb begin
    w_state_next  = r_state;
    w_level_next  = r_level;
    w_reload      = 1'b0;
    w_clear_kills = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_PLAY;
          w_level_next = 3'd1;
          w_reload     = 1'b1;
        end
      end
      ST_PLAY: begin
        if (|w_at_end)
          w_state_next = ST_LOSE;
        else if (&r_dead)
          w_state_next = (r_level == 3'(NUM_LEVELS)) ? ST_WIN : ST_NEXT;
      end
      ST_NEXT: begin
        if (start) begin
          w_state_next = ST_PLAY;
          w_level_next = r_level + 3'd1;
          w_reload     = 1'b1;
        end
      end
      default: begin
        if (start) begin
          w_state_next  = ST_IDLE;
          w_level_next  = 3'd1;
          w_reload      = 1'b1;
          w_clear_kills = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_level      <= 3'd1;
      r_state_oh   <= OH_I;
      r_div        <= '0;
      r_launch_cnt <= '0;
      r_killed     <= '0;
      r_dead       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_level    <= w_level_next;
      r_state_oh <= state_onehot(w_state_next, w_level_next);

      if (w_reload) begin
        r_div        <= '0;
        r_launch_cnt <= '0;
        r_dead       <= '0;
      end else if (w_playing) begin
        r_div  <= w_tick ? '0 : r_div + 1'b1;
        r_dead <= r_dead | w_kill_pulse;
        if (w_tick && (r_launch_cnt != LC_W'(LC_MAX)))
          r_launch_cnt <= r_launch_cnt + 1'b1;
      end

      if (w_clear_kills)
        r_killed <= '0;
      else if (w_kill_sum[KILL_W])
        r_killed <= '1;
      else
        r_killed <= w_kill_sum[KILL_W-1:0];
    end
  end

  assign zombies_killed = r_killed;
  assign level          = r_level;
  assign state          = r_state_oh;
  assign tick           = w_tick;

endmodule
